// File: rtl/watchdog_timer.sv
// Supervisory watchdog: counts cycles since the last heartbeat, raises a warning, then a timeout
// with a fixed-length force_reset pulse. Optional macro WDT_LATCH_EN makes triggered sticky until rst.
module watchdog_timer #(
    parameter int CNT_W              = 32,
    parameter int TIMEOUT_CYCLES     = 1000,
    parameter int WARN_CYCLES        = 750,
    parameter int RESET_PULSE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             heartbeat,
    output logic             force_reset,
    output logic             warning,
    output logic             triggered,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (RESET_PULSE_CYCLES > 1) ? $clog2(RESET_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_M1_C = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WARN_C       = CNT_W'(WARN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
    localparam logic [PW-1:0]    PULSE_LAST_C = PW'(RESET_PULSE_CYCLES - 1);
    localparam logic [PW-1:0]    PULSE_ONE_C  = PW'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             warning_r;
    logic             warning_nxt_s;
    logic             triggered_r;
    logic             triggered_nxt_s;
    logic             force_reset_r;
    logic             force_reset_nxt_s;
    logic [PW-1:0]    pulse_left_r;
    logic [PW-1:0]    pulse_left_nxt_s;
    logic             clear_s;
    logic             timeout_evt_s;
    logic             fire_s;

    // Timeout event: the count is about to reach TIMEOUT_CYCLES on this edge.
    always_comb begin
        clear_s       = !enable || heartbeat;
        timeout_evt_s = enable && !heartbeat && (count_r == TIMEOUT_M1_C);
`ifdef WDT_LATCH_EN
        fire_s        = timeout_evt_s && !triggered_r;
`else
        fire_s        = timeout_evt_s;
`endif
    end

    // Saturating cycles-since-heartbeat counter and warning flag.
    always_comb begin
        count_nxt_s   = count_r;
        warning_nxt_s = warning_r;
        if (clear_s) begin
            count_nxt_s   = {CNT_W{1'b0}};
            warning_nxt_s = 1'b0;
        end else begin
            if (count_r >= TIMEOUT_C) begin
                count_nxt_s = TIMEOUT_C;
            end else begin
                count_nxt_s = count_r + CNT_ONE_C;
            end
            if (count_nxt_s == WARN_C) begin
                warning_nxt_s = 1'b1;
            end else begin
                warning_nxt_s = warning_r;
            end
        end
    end

    // Triggered flag: set by a timeout, cleared by kick/disable unless latched.
    always_comb begin
        triggered_nxt_s = triggered_r;
`ifdef WDT_LATCH_EN
        if (timeout_evt_s) begin
            triggered_nxt_s = 1'b1;
        end else begin
            triggered_nxt_s = triggered_r;
        end
`else
        if (clear_s) begin
            triggered_nxt_s = 1'b0;
        end else if (timeout_evt_s) begin
            triggered_nxt_s = 1'b1;
        end else begin
            triggered_nxt_s = triggered_r;
        end
`endif
    end

    // Reset pulse generator; a heartbeat does not cut a running pulse short, a disable does.
    always_comb begin
        force_reset_nxt_s = 1'b0;
        pulse_left_nxt_s  = {PW{1'b0}};
        if (!enable) begin
            force_reset_nxt_s = 1'b0;
            pulse_left_nxt_s  = {PW{1'b0}};
        end else if (fire_s) begin
            force_reset_nxt_s = 1'b1;
            pulse_left_nxt_s  = PULSE_LAST_C;
        end else if (force_reset_r && (pulse_left_r != {PW{1'b0}})) begin
            force_reset_nxt_s = 1'b1;
            pulse_left_nxt_s  = pulse_left_r - PULSE_ONE_C;
        end else begin
            force_reset_nxt_s = 1'b0;
            pulse_left_nxt_s  = {PW{1'b0}};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r       <= {CNT_W{1'b0}};
            warning_r     <= 1'b0;
            triggered_r   <= 1'b0;
            force_reset_r <= 1'b0;
            pulse_left_r  <= {PW{1'b0}};
        end else begin
            count_r       <= count_nxt_s;
            warning_r     <= warning_nxt_s;
            triggered_r   <= triggered_nxt_s;
            force_reset_r <= force_reset_nxt_s;
            pulse_left_r  <= pulse_left_nxt_s;
        end
    end

    assign count       = count_r;
    assign warning     = warning_r;
    assign triggered   = triggered_r;
    assign force_reset = force_reset_r;

endmodule

// File: tb/tb_watchdog_timer.sv
// Directed bench for watchdog_timer with a behavioural model feeding an expected-value queue.
module tb_watchdog_timer;

    localparam int T = 8;
    localparam int W = 6;
    localparam int P = 3;
`ifdef WDT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef struct {
        logic [31:0] cnt;
        logic        warn;
        logic        trig;
        logic        frc;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        heartbeat = 1'b0;
    logic        force_reset;
    logic        warning;
    logic        triggered;
    logic [31:0] count;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   m_cnt = 0;
    bit   m_warn = 1'b0;
    bit   m_trig = 1'b0;
    int   m_pulse = 0;
    int   peak;
    bit   warn_seen, frc_seen;

    watchdog_timer #(
        .CNT_W(32), .TIMEOUT_CYCLES(T), .WARN_CYCLES(W), .RESET_PULSE_CYCLES(P)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .heartbeat(heartbeat),
        .force_reset(force_reset), .warning(warning), .triggered(triggered), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle, predict the outputs, then compare after the edge.
    task automatic step(input bit r, input bit en, input bit hb, input string tag);
        exp_t e;
        exp_t got;
        int   prev;
        rst = r; enable = en; heartbeat = hb;
        if (r) begin
            m_cnt = 0; m_warn = 0; m_trig = 0; m_pulse = 0;
        end else if (!en) begin
            m_cnt = 0; m_warn = 0; m_pulse = 0;
            if (!LATCH) m_trig = 0;
        end else begin
            if (m_pulse > 0) m_pulse--;
            if (hb) begin
                m_cnt = 0; m_warn = 0;
                if (!LATCH) m_trig = 0;
            end else begin
                prev = m_cnt;
                if (m_cnt < T) m_cnt++;
                if (prev == T - 1) begin
                    if (!(LATCH && m_trig)) m_pulse = P;
                    m_trig = 1;
                end
                if (m_cnt >= W) m_warn = 1;
            end
        end
        e.cnt = m_cnt; e.warn = m_warn; e.trig = m_trig; e.frc = (m_pulse > 0); e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({got.tag, ".count"}, count, got.cnt);
        chk({got.tag, ".warning"}, {31'd0, warning}, {31'd0, got.warn});
        chk({got.tag, ".triggered"}, {31'd0, triggered}, {31'd0, got.trig});
        chk({got.tag, ".force_reset"}, {31'd0, force_reset}, {31'd0, got.frc});
    endtask

    initial begin
        // 1: reset
        step(1'b1, 1'b1, 1'b0, "rst0");
        step(1'b1, 1'b1, 1'b0, "rst1");
        chk("rst_count", count, 32'd0);
        chk("rst_force", {31'd0, force_reset}, 32'd0);

        // 2: free-running timeout
        for (int i = 1; i <= 14; i++) begin
            step(1'b0, 1'b1, 1'b0, $sformatf("run%0d", i));
            if (i == 5)  chk("warn_before_6", {31'd0, warning}, 32'd0);
            if (i == 6)  chk("warn_at_6", {31'd0, warning}, 32'd1);
            if (i == 7)  chk("trig_before_8", {31'd0, triggered}, 32'd0);
            if (i == 8)  chk("force_at_8", {31'd0, force_reset}, 32'd1);
            if (i == 10) chk("force_at_10", {31'd0, force_reset}, 32'd1);
            if (i == 11) chk("force_off_11", {31'd0, force_reset}, 32'd0);
        end
        chk("count_saturated", count, 32'd8);
        chk("trig_held", {31'd0, triggered}, 32'd1);

        // 3: periodic heartbeat keeps the watchdog quiet
        peak = 0; warn_seen = 0; frc_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, (i % 5) == 0, $sformatf("hb%0d", i));
            if (count > peak) peak = count;
            warn_seen |= warning;
            frc_seen  |= force_reset;
        end
        chk("hb_peak_below_warn", {31'd0, peak < W}, 32'd1);
        chk("hb_no_warning", {31'd0, warn_seen}, 32'd0);
        chk("hb_no_force", {31'd0, frc_seen}, 32'd0);

        // 4: heartbeat at count 7 blocks the timeout
        step(1'b1, 1'b1, 1'b0, "t4rst");
        for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 1'b0, $sformatf("t4run%0d", i));
        chk("t4_count7", count, 32'd7);
        chk("t4_warn7", {31'd0, warning}, 32'd1);
        step(1'b0, 1'b1, 1'b1, "t4kick");
        chk("t4_kick_count", count, 32'd0);
        chk("t4_kick_warn", {31'd0, warning}, 32'd0);
        step(1'b0, 1'b1, 1'b0, "t4after");
        chk("t4_no_trig", {31'd0, triggered}, 32'd0);

        // 5: disable / reset during the pulse
        step(1'b1, 1'b1, 1'b0, "t5rst");
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, $sformatf("t5run%0d", i));
        step(1'b0, 1'b0, 1'b0, "t5dis");
        chk("t5_dis_force", {31'd0, force_reset}, 32'd0);
        chk("t5_dis_count", count, 32'd0);
        step(1'b1, 1'b1, 1'b0, "t5rst2");
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, $sformatf("t5brun%0d", i));
        step(1'b1, 1'b1, 1'b0, "t5rstpulse");
        chk("t5_rst_trig", {31'd0, triggered}, 32'd0);
        chk("t5_rst_force", {31'd0, force_reset}, 32'd0);

        // 6: heartbeat after timeout, then a second full timeout
        for (int i = 1; i <= 11; i++) step(1'b0, 1'b1, 1'b0, $sformatf("t6run%0d", i));
        step(1'b0, 1'b1, 1'b1, "t6kick");
        chk("t6_kick_trig", {31'd0, triggered}, {31'd0, LATCH});
        chk("t6_kick_count", count, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b1, 1'b0, $sformatf("t6again%0d", i));
            if (i == 8) chk("t6_second_pulse", {31'd0, force_reset}, {31'd0, !LATCH});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
